// File: rtl/rv32_pkg.sv
// Shared RV32I load/store definitions: widths, funct3 encodings, LSU states,
// and access-size helpers used by the memory stage and its lane aligner.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Reserved funct3 codes (011, 110, 111) fall through to a full-word access.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    lsu_size_t sz;
    sz = SZ_W;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic [1:0] align_off(input lsu_size_t sz, input logic [1:0] off);
    logic [1:0] o;
    o = off;
    case (sz)
      SZ_H:    o = {off[1], 1'b0};
      SZ_W:    o = 2'b00;
      default: o = off;
    endcase
    return o;
  endfunction

  function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] off);
    logic m;
    m = 1'b0;
    case (sz)
      SZ_H:    m = off[0];
      SZ_W:    m = |off;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the LSU (master) and the memory system (slave):
// request/grant handshake plus a separate read-valid return.
interface lsu_mem_stage_if;
  import rv32_pkg::*;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/replicated data and load extraction with
// sign or zero extension. The offset arrives already aligned to the access size.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] ld_word,
  output logic [3:0]      st_strb,
  output logic [XLEN-1:0] st_wdata,
  output logic [XLEN-1:0] ld_data
);

  lsu_size_t   sz;
  logic        sgn;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign sz      = f3_size(funct3);
  assign sgn     = (funct3 == F3_B) || (funct3 == F3_H);
  assign ld_byte = ld_word[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    st_strb  = 4'hF;
    st_wdata = st_data;
    ld_data  = ld_word;
    case (sz)
      SZ_B: begin
        st_strb  = 4'b0001 << off;
        st_wdata = {4{st_data[7:0]}};
        ld_data  = {{24{sgn & ld_byte[7]}}, ld_byte};
      end
      SZ_H: begin
        st_strb  = 4'b0011 << off;
        st_wdata = {2{st_data[15:0]}};
        ld_data  = {{16{sgn & ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I memory-access stage: one bus transaction per request, result to write-back.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned accesses into an error response.
//
// state | meaning
// IDLE  | ready for a new request; request fields latched on req_valid
// REQ   | mem_req held with stable address/data until mem_gnt
// WAIT  | load granted, waiting for mem_rvalid
// RESP  | one-cycle resp_valid to write-back
module lsu_mem_stage
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [RD_W-1:0] req_rd,
  output logic            resp_valid,
  output logic            resp_wb,
  output logic [RD_W-1:0] resp_rd,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  lsu_mem_stage_if.master mem
);

  lsu_state_t      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  lsu_size_t       req_sz;
  logic [1:0]      req_off;
  logic [3:0]      lane_strb;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] lane_rdata;
  logic            in_req;

  assign req_sz  = f3_size(req_funct3);
  assign req_off = align_off(req_sz, req_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_mis;
  assign req_mis = is_misaligned(req_sz, req_addr[1:0]);
`endif

  lsu_align u_align (
    .funct3   (funct3_q),
    .off      (addr_q[1:0]),
    .st_data  (wdata_q),
    .ld_word  (mem.mem_rdata),
    .st_strb  (lane_strb),
    .st_wdata (lane_wdata),
    .ld_data  (lane_rdata)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = {req_addr[XLEN-1:2], req_off};
          wdata_d  = req_wdata;
          rd_d     = req_rd;
          rdata_d  = '0;
          err_d    = 1'b0;
          state_d  = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          if (req_mis) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
`endif
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          if (we_q) begin
            state_d = RESP;
          end else if (mem.mem_rvalid) begin
            // zero-latency read: data arrives with the grant
            rdata_d = lane_rdata;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          rdata_d = lane_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Bus outputs are gated to zero outside REQ so the bus is quiet when idle.
  assign in_req        = (state_q == REQ);
  assign req_ready     = (state_q == IDLE);
  assign mem.mem_req   = in_req;
  assign mem.mem_we    = in_req & we_q;
  assign mem.mem_addr  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem.mem_wstrb = (in_req & we_q) ? lane_strb : 4'h0;
  assign mem.mem_wdata = (in_req & we_q) ? lane_wdata : '0;

  assign resp_valid = (state_q == RESP);
  assign resp_wb    = resp_valid & ~we_q & ~err_q;
  assign resp_rd    = resp_valid ? rd_q : '0;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule
